// File: rtl/ex_mdu_pkg.sv
// ---------------------------------------------------------------------------
// ex_mdu_pkg : shared types and constants for the EX-stage multiply/divide unit
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package ex_mdu_pkg;

  typedef enum logic [2:0] {
    MDU_MUL    = 3'd0,
    MDU_MULH   = 3'd1,
    MDU_MULHSU = 3'd2,
    MDU_MULHU  = 3'd3,
    MDU_DIV    = 3'd4,
    MDU_DIVU   = 3'd5,
    MDU_REM    = 3'd6,
    MDU_REMU   = 3'd7
  } mdu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } mdu_state_e;

  localparam int MDU_ITER_D = 64;
  localparam int MDU_ITER_W = 32;
  localparam int MDU_CNT_W  = 7;

endpackage

`default_nettype wire

// File: rtl/mdu_div_step.sv
// ---------------------------------------------------------------------------
// mdu_div_step : one combinational restoring-division step
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mdu_div_step #(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] rem_in,
  input  logic [XLEN-1:0] quo_in,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_out,
  output logic [XLEN-1:0] quo_out
);

  // Shifted partial remainder needs one extra bit before the compare.
  logic [XLEN:0] shifted;

  assign shifted = {rem_in, quo_in[XLEN-1]};

  always_comb begin
    rem_out = shifted[XLEN-1:0];
    quo_out = {quo_in[XLEN-2:0], 1'b0};
    if (shifted >= {1'b0, divisor}) begin
      rem_out = shifted[XLEN-1:0] - divisor;
      quo_out = {quo_in[XLEN-2:0], 1'b1};
    end
  end

endmodule

`default_nettype wire

// File: rtl/ex_muldiv_unit.sv
// ---------------------------------------------------------------------------
// ex_muldiv_unit : iterative RV64M multiply/divide unit, stalls ID/EX via busy
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ex_muldiv_unit
  import ex_mdu_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic            word,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  mdu_state_e             state;
  mdu_op_e                op_q;
  logic                   word_q;
  logic                   neg_q;
  logic                   neg_r;
  logic [MDU_CNT_W-1:0]   cnt;
  logic [2*XLEN-1:0]      acc;
  logic [2*XLEN-1:0]      mcand;
  logic [XLEN-1:0]        mplier;
  logic [XLEN-1:0]        rem;
  logic [XLEN-1:0]        quo;
  logic [XLEN-1:0]        dvsr;

  mdu_op_e                op_in;
  logic                   a_signed, b_signed, a_neg, b_neg;
  logic                   is_div, div_zero, div_ovf;
  logic [XLEN-1:0]        a_op, b_op, a_mag, b_mag, most_neg, special_raw;

  logic [2*XLEN-1:0]      acc_nx, mul_full;
  logic [XLEN-1:0]        rem_nx, quo_nx, q_fix, r_fix, raw_res, final_res;

  function automatic logic [XLEN-1:0] fit(input logic w, input logic [XLEN-1:0] v);
    return w ? {{(XLEN-32){v[31]}}, v[31:0]} : v;
  endfunction

  assign op_in = mdu_op_e'(op);

  // Operand preparation for the accept edge.
  always_comb begin
    a_signed = (op_in == MDU_MUL) || (op_in == MDU_MULH) || (op_in == MDU_MULHSU) ||
               (op_in == MDU_DIV) || (op_in == MDU_REM);
    b_signed = (op_in == MDU_MUL) || (op_in == MDU_MULH) ||
               (op_in == MDU_DIV) || (op_in == MDU_REM);
    is_div   = op[2];
    a_op     = src1;
    b_op     = src2;
    if (word) begin
      a_op = a_signed ? {{(XLEN-32){src1[31]}}, src1[31:0]} : {{(XLEN-32){1'b0}}, src1[31:0]};
      b_op = b_signed ? {{(XLEN-32){src2[31]}}, src2[31:0]} : {{(XLEN-32){1'b0}}, src2[31:0]};
    end
    a_neg    = a_signed & a_op[XLEN-1];
    b_neg    = b_signed & b_op[XLEN-1];
    a_mag    = a_neg ? (~a_op + 1'b1) : a_op;
    b_mag    = b_neg ? (~b_op + 1'b1) : b_op;
    most_neg = word ? {{(XLEN-31){1'b1}}, 31'b0} : {1'b1, {(XLEN-1){1'b0}}};
    div_zero = is_div && (b_op == '0);
    div_ovf  = is_div && a_signed && (a_op == most_neg) && (b_op == '1);
    special_raw = '0;
    if (div_zero) begin
      special_raw = ((op_in == MDU_DIV) || (op_in == MDU_DIVU)) ? '1 : a_op;
    end else if (div_ovf) begin
      special_raw = (op_in == MDU_DIV) ? a_op : '0;
    end
  end

  mdu_div_step #(.XLEN(XLEN)) u_div_step (
    .rem_in  (rem),
    .quo_in  (quo),
    .divisor (dvsr),
    .rem_out (rem_nx),
    .quo_out (quo_nx)
  );

  // Inline shift-add multiply step plus sign fix-up of the final iteration.
  always_comb begin
    acc_nx    = mplier[0] ? (acc + mcand) : acc;
    mul_full  = neg_q ? (~acc_nx + 1'b1) : acc_nx;
    q_fix     = neg_q ? (~quo_nx + 1'b1) : quo_nx;
    r_fix     = neg_r ? (~rem_nx + 1'b1) : rem_nx;
    if (op_q[2]) begin
      raw_res = ((op_q == MDU_DIV) || (op_q == MDU_DIVU)) ? q_fix : r_fix;
    end else begin
      raw_res = (op_q == MDU_MUL) ? mul_full[XLEN-1:0] : mul_full[2*XLEN-1:XLEN];
    end
    final_res = fit(word_q, raw_res);
  end

  assign busy = rst_n & (((state == IDLE) & start) | (state == CALC));

  always_ff @(negedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      result <= '0;
      done   <= 1'b0;
    end else if (flush) begin
      state <= IDLE;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            op_q   <= op_in;
            word_q <= word;
            cnt    <= word ? MDU_CNT_W'(MDU_ITER_W) : MDU_CNT_W'(MDU_ITER_D);
            acc    <= '0;
            mcand  <= {{XLEN{1'b0}}, a_mag};
            mplier <= b_mag;
            rem    <= '0;
            // W dividends start in the upper half so 32 steps drain them.
            quo    <= word ? (a_mag << (XLEN-32)) : a_mag;
            dvsr   <= b_mag;
            neg_q  <= a_neg ^ b_neg;
            neg_r  <= a_neg;
            if (div_zero || div_ovf) begin
              result <= fit(word, special_raw);
              done   <= 1'b1;
              state  <= DONE;
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          acc    <= acc_nx;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          rem    <= rem_nx;
          quo    <= quo_nx;
          cnt    <= cnt - 1'b1;
          if (cnt == MDU_CNT_W'(1)) begin
            result <= final_res;
            done   <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ex_muldiv_unit.sv
// ---------------------------------------------------------------------------
// tb_ex_muldiv_unit : directed self-checking bench with a behavioural model
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_ex_muldiv_unit;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        start = 1'b0;
  logic        word  = 1'b0;
  logic [2:0]  op    = 3'd0;
  logic [63:0] src1  = 64'd0;
  logic [63:0] src2  = 64'd0;
  logic        busy;
  logic        done;
  logic [63:0] result;

  int   checks = 0;
  int   errors = 0;
  logic chk_en = 1'b0;

  always #5 clk = ~clk;

  ex_muldiv_unit #(.XLEN(64)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .flush  (flush),
    .start  (start),
    .op     (op),
    .word   (word),
    .src1   (src1),
    .src2   (src2),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- reference arithmetic ----------------
  function automatic logic [63:0] sx32(input logic [63:0] v);
    return {{32{v[31]}}, v[31:0]};
  endfunction

  function automatic logic [63:0] opnd(input logic [63:0] v, input logic w, input logic sgn);
    if (!w) return v;
    return sgn ? sx32(v) : {32'b0, v[31:0]};
  endfunction

  function automatic logic sdiv(input logic [2:0] o);
    return (o == 3'd4) || (o == 3'd6);
  endfunction

  function automatic logic is_special(input logic [2:0] o, input logic w,
                                      input logic [63:0] a, input logic [63:0] b);
    logic [63:0] x, y;
    if (!o[2]) return 1'b0;
    x = opnd(a, w, sdiv(o));
    y = opnd(b, w, sdiv(o));
    if (y == 64'd0) return 1'b1;
    return sdiv(o) && (y == '1) &&
           (x == (w ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000));
  endfunction

  function automatic logic [63:0] ref_result(input logic [2:0] o, input logic w,
                                             input logic [63:0] a, input logic [63:0] b);
    logic [127:0] p;
    logic [63:0]  x, y, r;
    logic         sg;
    sg = sdiv(o);
    x  = opnd(a, w, sg);
    y  = opnd(b, w, sg);
    r  = 64'd0;
    case (o)
      3'd0: r = a * b;
      3'd1: begin p = {{64{a[63]}}, a} * {{64{b[63]}}, b}; r = p[127:64]; end
      3'd2: begin p = {{64{a[63]}}, a} * {64'b0, b};       r = p[127:64]; end
      3'd3: begin p = {64'b0, a} * {64'b0, b};             r = p[127:64]; end
      default: begin
        if (y == 64'd0)               r = ((o == 3'd4) || (o == 3'd5)) ? '1 : x;
        else if (is_special(o, w, a, b)) r = (o == 3'd4) ? x : 64'd0;
        else if (sg)                  r = (o == 3'd4) ? $signed(x) / $signed(y) : $signed(x) % $signed(y);
        else                          r = (o == 3'd5) ? x / y : x % y;
      end
    endcase
    return w ? sx32(r) : r;
  endfunction

  // ---------------- cycle model: phase 0 idle, 1 iterating, 2 result ----------------
  int          m_phase = 0;
  int          m_left  = 0;
  logic [63:0] m_res   = 64'd0;
  logic [63:0] m_pend  = 64'd0;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_phase <= 0;
      m_res   <= 64'd0;
    end else if (flush) begin
      m_phase <= 0;
    end else begin
      case (m_phase)
        0: if (start) begin
          if (is_special(op, word, src1, src2)) begin
            m_phase <= 2;
            m_res   <= ref_result(op, word, src1, src2);
          end else begin
            m_phase <= 1;
            m_left  <= word ? 32 : 64;
            m_pend  <= ref_result(op, word, src1, src2);
          end
        end
        1: begin
          m_left <= m_left - 1;
          if (m_left == 1) begin
            m_phase <= 2;
            m_res   <= m_pend;
          end
        end
        default: m_phase <= 0;
      endcase
    end
  end

  always @(posedge clk) begin
    if (chk_en) begin
      #2;
      check("cyc busy",   64'(busy), 64'(rst_n && ((m_phase == 0 && start) || m_phase == 1)));
      check("cyc done",   64'(done), 64'(m_phase == 2));
      check("cyc result", result, m_res);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic run_op(input string name, input logic [2:0] o, input logic w,
                        input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] exp, input int lat);
    int   edges;
    int   bc;
    logic seen;
    check({name, " model"}, ref_result(o, w, a, b), exp);
    @(posedge clk);
    #1 start = 1'b1; op = o; word = w; src1 = a; src2 = b;
    #1 bc = busy ? 1 : 0;
    edges = 0;
    seen  = 1'b0;
    for (int k = 0; k < 200 && !seen; k++) begin
      @(negedge clk);
      edges++;
      @(posedge clk);
      #2;
      if (done) seen = 1'b1;
      else if (busy) bc++;
    end
    check({name, " done seen"},   64'(seen), 64'd1);
    check({name, " result"},      result, exp);
    check({name, " latency"},     64'(edges - 1), 64'(lat));
    check({name, " busy cycles"}, 64'(bc), 64'(lat + 1));
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    @(posedge clk);
    #1 start = 1'b0;
    repeat (n) @(posedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    check("reset busy",   64'(busy), 64'd0);
    check("reset done",   64'(done), 64'd0);
    check("reset result", result, 64'd0);
    chk_en = 1'b1;

    run_op("MUL 7*-3",     3'd0, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 64);
    run_op("MULHU ff*2",   3'd3, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'd1, 64);
    run_op("MULH -1*-1",   3'd1, 1'b0, '1, '1, 64'd0, 64);
    run_op("MULHSU -1*2",  3'd2, 1'b0, '1, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64);
    run_op("MULW",         3'd0, 1'b1, 64'h7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 32);
    idle(2);
    run_op("DIV by 0",     3'd4, 1'b0, 64'd100, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 0);
    run_op("REM by 0",     3'd6, 1'b0, 64'd100, 64'd0, 64'd100, 0);
    run_op("DIV ovf",      3'd4, 1'b0, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 0);
    run_op("REMW ovf",     3'd6, 1'b1, 64'h8000_0000, '1, 64'd0, 0);
    run_op("DIVW -7/2",    3'd4, 1'b1, 64'h1_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 32);
    run_op("REMW -7/2",    3'd6, 1'b1, 64'h1_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 32);
    run_op("DIV -7/2",     3'd4, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 64);
    run_op("REMU 100/7",   3'd7, 1'b0, 64'd100, 64'd7, 64'd2, 64);
    run_op("DIVUW",        3'd5, 1'b1, 64'hFFFF_FFFF, 64'd2, 64'h7FFF_FFFF, 32);
    idle(2);

    // Flush on the tenth iteration edge.
    @(posedge clk);
    #1 start = 1'b1; op = 3'd0; word = 1'b0; src1 = 64'd7; src2 = 64'hFFFF_FFFF_FFFF_FFFD;
    @(negedge clk);
    repeat (9) @(negedge clk);
    @(posedge clk);
    #1 flush = 1'b1; start = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #1 flush = 1'b0;
    #1;
    check("flush busy",   64'(busy), 64'd0);
    check("flush done",   64'(done), 64'd0);
    check("flush result", result, 64'h7FFF_FFFF);
    repeat (5) @(posedge clk);

    // Reset on the twentieth iteration edge; busy must already be forced low.
    @(posedge clk);
    #1 start = 1'b1; op = 3'd4; word = 1'b0; src1 = 64'd100; src2 = 64'd7;
    @(negedge clk);
    repeat (19) @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1 check("rst busy forced", 64'(busy), 64'd0);
    @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1; start = 1'b0;
    #1;
    check("rst result", result, 64'd0);
    check("rst busy",   64'(busy), 64'd0);
    check("rst done",   64'(done), 64'd0);
    repeat (2) @(posedge clk);

    run_op("DIVU 9/4",     3'd5, 1'b0, 64'd9, 64'd4, 64'd2, 64);
    idle(3);
    chk_en = 1'b0;
    #3;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
